ghash_seq: RTL
==============

GHASH_SEQ -- requirements
Module: ghash_seq

Interface
REQ-001 clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 init  in  1  one-cycle pulse; starts a new GHASH message.
REQ-004 h_i  in  128  hash key H; sampled on accepted init.
REQ-005 blk_valid  in  1  input block present.
REQ-006 blk_last  in  1  qualifies blk_data as the final data block.
REQ-007 blk_data  in  128  data block.
REQ-008 blk_ready  out  1  block accepted when blk_valid and blk_ready are both high.
REQ-009 mul_start  out  1  one-cycle start pulse to the GF(2^128) multiplier core.
REQ-010 mul_h  out  128  latched H to the multiplier.
REQ-011 mul_block  out  128  multiplier operand, registered.
REQ-012 mul_ready  in  1  one-cycle done pulse from the multiplier.
REQ-013 mul_result  in  128  product, valid while mul_ready is high.
REQ-014 tag_o  out  128  GHASH result, registered.
REQ-015 tag_valid  out  1  level; high from completion until the next accepted init.

Function
REQ-016 Operation: Y0 = 0; Yi = (Yi-1 xor Xi) * H; tag = final Y.
REQ-017 FSM states are IDLE, WAIT_BLK, MUL_GO, MUL_WAIT, LEN (compiled per REQ-033), and DONE.
REQ-018 IDLE: init -> Y=0, blk_cnt=0, mul_h=h_i, tag_valid=0, go WAIT_BLK; all other inputs are ignored.
REQ-019 WAIT_BLK: blk_ready=1; on handshake, mul_block <= Y xor blk_data, last_flag <= blk_last, blk_cnt += 1, go MUL_GO.
REQ-020 blk_ready is 0 in every state except WAIT_BLK, so at most one block is accepted per multiplication.
REQ-021 MUL_GO: mul_start=1 for exactly one cycle, then go MUL_WAIT.
REQ-022 MUL_WAIT: mul_ready is honoured only in this state; on mul_ready, Y <= mul_result.
REQ-023 MUL_WAIT exit: if last_flag is 0, go WAIT_BLK.
REQ-024 MUL_WAIT exit: if last_flag is 1, go LEN when the macro is defined, else DONE.
REQ-025 MUL_WAIT exit: after the length-block multiply, go DONE.
REQ-026 DONE: tag_o <= Y, tag_valid <= 1, go IDLE; the tag is visible the cycle after DONE.
REQ-027 blk_cnt is 32 bits and wraps modulo 2^32 with no error flag.
REQ-028 init is ignored in every state except IDLE (no abort); mul_ready outside MUL_WAIT is ignored.
REQ-029 Latency per block: 1 (accept) + 1 (MUL_GO) + multiplier latency to mul_ready + 1.
REQ-030 mul_ready and blk_valid in the same cycle: no conflict, since they are only sampled in disjoint states.

Reset
REQ-031 reset, synchronous: state=IDLE; Y, mul_block, mul_h, tag_o = 0; blk_cnt=0; last_flag=0.
REQ-032 reset outputs: tag_valid, blk_ready, mul_start = 0; reset mid-message discards all progress, and a pending mul_ready is then ignored.

Configuration
REQ-033 Macro GHASH_SEQ_LENBLK_EN defined: the LEN state exists.
REQ-034 In LEN: mul_block <= Y xor {64'h0, 25'h0, blk_cnt, 7'h0} (bit length of the data); set a len_phase flag and go MUL_GO.
REQ-035 Macro GHASH_SEQ_LENBLK_EN not defined: the LEN state and len_phase are absent, and the tag is taken after the last data block.

Verification
REQ-036 Bench uses the team's 128-bit multiplier core on mul_*. Scenario: h_i=128'h0, one block 128'h1234 with last=1 -> tag_o=0, tag_valid=1.
REQ-037 Scenario: h_i=128'h80..0 (GF one), blk_data=128'h01, last=1, macro off -> tag_o=128'h01.
REQ-038 Scenario: same stimulus as REQ-037, macro on -> tag_o=128'h01 xor 128'h80 = 128'h81.
REQ-039 Scenario: h_i=GF one, blocks 128'hA then 128'h5 (last) -> tag_o=128'hF (macro off).
REQ-040 Scenario: init pulses during MUL_WAIT and blk_valid held high during MUL_WAIT -> both ignored; exactly one mul_start per accepted block.
REQ-041 Scenario: reset asserted in MUL_WAIT, then mul_ready pulses -> state stays IDLE, tag_valid=0, Y=0.

Source files
------------

// File: rtl/ghash_seq.sv
// ---------------------------------------------------------------------------
// ghash_seq -- sequential GHASH controller
//
// Computes Y0 = 0, Yi = (Yi-1 xor Xi) * H over a stream of 128-bit blocks.
// The GF(2^128) multiplication is done by an external multiplier core. This
// block hands it one operand pair per block over the mul_* signals and waits
// for the product. The final Y is presented on tag_o.
//
// Optional feature (macro GHASH_SEQ_LENBLK_EN):
//   When defined, a LEN state runs one extra multiply after the last data
//   block. It folds in the message bit length, blk_cnt * 128, in the low
//   64 bits of the length block. When undefined, the tag is taken straight
//   after the last data block.
//
// Ports:
//   clk         in   1    sole clock, rising edge
//   reset       in   1    synchronous, active-high
//   init        in   1    start-of-message pulse (honoured only in IDLE)
//   h_i         in   128  hash key H, latched on accepted init
//   blk_valid   in   1    data block present
//   blk_last    in   1    marks blk_data as the final data block
//   blk_data    in   128  data block
//   blk_ready   out  1    high only while waiting for a block
//   mul_start   out  1    one-cycle start pulse to the multiplier
//   mul_h       out  128  latched H for the multiplier
//   mul_block   out  128  multiplier operand (Y xor X)
//   mul_ready   in   1    one-cycle done pulse (honoured only in MUL_WAIT)
//   mul_result  in   128  product, valid with mul_ready
//   tag_o       out  128  GHASH result
//   tag_valid   out  1    high from completion until the next accepted init
// ---------------------------------------------------------------------------
module ghash_seq (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic [127:0] h_i,
  input  logic         blk_valid,
  input  logic         blk_last,
  input  logic [127:0] blk_data,
  output logic         blk_ready,
  output logic         mul_start,
  output logic [127:0] mul_h,
  output logic [127:0] mul_block,
  input  logic         mul_ready,
  input  logic [127:0] mul_result,
  output logic [127:0] tag_o,
  output logic         tag_valid
);

`ifdef GHASH_SEQ_LENBLK_EN
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_BLK = 3'd1,
    MUL_GO   = 3'd2,
    MUL_WAIT = 3'd3,
    LEN      = 3'd4,
    DONE     = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_BLK = 3'd1,
    MUL_GO   = 3'd2,
    MUL_WAIT = 3'd3,
    DONE     = 3'd5
  } state_t;
`endif

  state_t        state_reg;
  logic [127:0]  y_reg;          // running hash value Y
  logic [31:0]   blk_cnt_reg;    // data blocks accepted; wraps silently
  logic          last_flag_reg;  // block in flight was the final data block
`ifdef GHASH_SEQ_LENBLK_EN
  logic          len_phase_reg;  // multiply in flight is the length block
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      y_reg         <= '0;
      blk_cnt_reg   <= '0;
      last_flag_reg <= 1'b0;
`ifdef GHASH_SEQ_LENBLK_EN
      len_phase_reg <= 1'b0;
`endif
      mul_block     <= '0;
      mul_h         <= '0;
      tag_o         <= '0;
      tag_valid     <= 1'b0;
      blk_ready     <= 1'b0;
      mul_start     <= 1'b0;
    end else begin
      // mul_start is raised only on entry to MUL_GO, so it lasts exactly
      // the one cycle spent in that state.
      mul_start <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (init) begin
            y_reg         <= '0;
            blk_cnt_reg   <= '0;
            last_flag_reg <= 1'b0;
`ifdef GHASH_SEQ_LENBLK_EN
            len_phase_reg <= 1'b0;
`endif
            mul_h         <= h_i;
            tag_valid     <= 1'b0;
            blk_ready     <= 1'b1;
            state_reg     <= WAIT_BLK;
          end
        end

        WAIT_BLK: begin
          if (blk_valid && blk_ready) begin
            mul_block     <= y_reg ^ blk_data;
            last_flag_reg <= blk_last;
            blk_cnt_reg   <= blk_cnt_reg + 32'd1;
            blk_ready     <= 1'b0;
            mul_start     <= 1'b1;
            state_reg     <= MUL_GO;
          end
        end

        MUL_GO: begin
          state_reg <= MUL_WAIT;
        end

        MUL_WAIT: begin
          if (mul_ready) begin
            y_reg <= mul_result;
`ifdef GHASH_SEQ_LENBLK_EN
            if (len_phase_reg) begin
              state_reg <= DONE;
            end else if (last_flag_reg) begin
              state_reg <= LEN;
            end else begin
              blk_ready <= 1'b1;
              state_reg <= WAIT_BLK;
            end
`else
            if (last_flag_reg) begin
              state_reg <= DONE;
            end else begin
              blk_ready <= 1'b1;
              state_reg <= WAIT_BLK;
            end
`endif
          end
        end

`ifdef GHASH_SEQ_LENBLK_EN
        LEN: begin
          // Length block: upper 64 bits (AAD length) are zero. The low 64
          // bits carry blk_cnt * 128, the data length in bits.
          mul_block     <= y_reg ^ {64'h0, 25'h0, blk_cnt_reg, 7'h0};
          len_phase_reg <= 1'b1;
          mul_start     <= 1'b1;
          state_reg     <= MUL_GO;
        end
`endif

        DONE: begin
          tag_o     <= y_reg;
          tag_valid <= 1'b1;
          state_reg <= IDLE;
        end

        default: begin
          blk_ready <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
